// File: rtl/io_read_arbiter.sv
// ---------------------------------------------------------------------------
// io_read_arbiter
//
// Shares the CPU data-bus read path between the I/O read responders
// (port decode, Kempston, DivMMC, AY). When an IORQ read cycle starts, the
// block waits SETTLE clk28 edges so the responders' registered decode can
// settle. It then grants exactly one responder by fixed priority (index 0
// is highest) and holds that grant until the read cycle ends.
//
// Parameters:
//   N_SRC   number of read sources (index 0 = highest priority)
//   SETTLE  clk28 edges between sampling the request and arbitrating (>= 1)
//
// Ports:
//   clk28          system clock, 28 MHz
//   rst            synchronous, active-high reset
//   ioreq, rd      CPU I/O request and read strobe; req = ioreq && rd
//   src_active     per-source "I decode this address" flags (registered)
//   src_data       per-source data bytes, source i at [8*i+7:8*i]
//   d_out          registered data toward the CPU bus (8'hFF when idle)
//   d_out_active   registered bus-drive enable
//   grant          one-hot grant, or all zero
//   conflict       one-cycle pulse when >1 source is active at arbitration
//   conflict_clr   clears the conflict log (logging build only)
//   conflict_cnt   saturating conflict count (logging build only, else 0)
//   conflict_mask  src_active captured at the last conflict (logging build)
//   dbg_state      current FSM state, for checkers and debug
//
// Build option:
//   IO_ARB_CONFLICT_LOG_EN  when defined, conflict_cnt/conflict_mask are
//                           live registers and conflict_clr is honoured.
//                           When undefined, they are tied to 0 and
//                           conflict_clr is ignored.
//
// Bus-drive semantics: d_out_active behaves as a "valid" with no back
// pressure. While it is high, d_out is the byte the top-level buffer must
// drive onto the CPU bus. d_out_active rises on the arbitration edge only
// if some source decodes the address, and it falls on the first edge that
// samples req low. There is no ready; the CPU read cycle itself is the
// consumer.
// ---------------------------------------------------------------------------
module io_read_arbiter #(
  parameter int N_SRC  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk28,
  input  logic                 rst,
  input  logic                 ioreq,
  input  logic                 rd,
  input  logic [N_SRC-1:0]     src_active,
  input  logic [8*N_SRC-1:0]   src_data,
  output logic [7:0]           d_out,
  output logic                 d_out_active,
  output logic [N_SRC-1:0]     grant,
  output logic                 conflict,
  input  logic                 conflict_clr,
  output logic [7:0]           conflict_cnt,
  output logic [N_SRC-1:0]     conflict_mask,
  output logic [1:0]           dbg_state
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wait_low_q, wait_low_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [7:0]       d_out_q, d_out_d;
  logic             d_act_q, d_act_d;
  logic             conflict_q, conflict_d;

  logic             req;
  logic             pick_any;
  logic [IW-1:0]    pick_idx;
  logic [N_SRC-1:0] pick_onehot;
  logic [7:0]       pick_data;
  logic [7:0]       hold_data;
  logic             multi_active;

  assign req = ioreq & rd;

  // Fixed-priority pick: scanning from the top down leaves the lowest set
  // index as the final assignment.
  always_comb begin
    pick_any    = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_active[i]) begin
        pick_any    = 1'b1;
        pick_idx    = IW'(i);
        pick_onehot = '0;
        pick_onehot[i] = 1'b1;
      end
    end
  end

  assign pick_data = src_data[{pick_idx, 3'b000} +: 8];
  assign hold_data = src_data[{gidx_q, 3'b000} +: 8];

  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign multi_active = |(src_active & (src_active - N_SRC'(1)));

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_low_d = wait_low_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    d_out_d    = d_out_q;
    d_act_d    = d_act_q;
    conflict_d = 1'b0;

    // After reset, a cycle may start only once req has been seen low. This
    // stops a req that is still high from re-arbitrating.
    if (!req) begin
      wait_low_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req && !wait_low_q) begin
          state_d = S_ARB;
          cnt_d   = '0;
        end
      end

      S_ARB: begin
        if (!req) begin
          // Aborted before the decode settled: no grant, no conflict.
          state_d = S_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d    = S_HOLD;
          grant_d    = pick_onehot;
          gidx_d     = pick_idx;
          d_act_d    = pick_any;
          d_out_d    = pick_any ? pick_data : 8'hFF;
          conflict_d = multi_active;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HOLD: begin
        if (!req) begin
          state_d = S_IDLE;
          grant_d = '0;
          d_act_d = 1'b0;
          d_out_d = 8'hFF;
        end else if (d_act_q && src_active[gidx_q]) begin
          // Track the granted source. If it drops out, the last byte
          // stays on the bus until the cycle ends.
          d_out_d = hold_data;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wait_low_q <= 1'b1;
      gidx_q     <= '0;
      grant_q    <= '0;
      d_out_q    <= 8'hFF;
      d_act_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_low_q <= wait_low_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      d_out_q    <= d_out_d;
      d_act_q    <= d_act_d;
      conflict_q <= conflict_d;
    end
  end

  assign d_out        = d_out_q;
  assign d_out_active = d_act_q;
  assign grant        = grant_q;
  assign conflict     = conflict_q;
  assign dbg_state    = state_q;

`ifdef IO_ARB_CONFLICT_LOG_EN
  logic [7:0]       log_cnt_q;
  logic [N_SRC-1:0] log_mask_q;

  // A clear wins over a conflict on the same edge.
  always_ff @(posedge clk28) begin
    if (rst) begin
      log_cnt_q  <= '0;
      log_mask_q <= '0;
    end else if (conflict_clr) begin
      log_cnt_q  <= '0;
      log_mask_q <= '0;
    end else if (conflict_d) begin
      if (log_cnt_q != 8'hFF) begin
        log_cnt_q <= log_cnt_q + 8'd1;
      end
      log_mask_q <= src_active;
    end
  end

  assign conflict_cnt  = log_cnt_q;
  assign conflict_mask = log_mask_q;
`else
  logic unused_conflict_clr;
  assign unused_conflict_clr = conflict_clr;
  assign conflict_cnt        = '0;
  assign conflict_mask       = '0;
`endif

endmodule

// File: tb/tb_io_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_io_read_arbiter
//
// Bench for io_read_arbiter with N_SRC=4 and SETTLE=2. The driver applies
// one clk28 edge of stimulus at a time. At each edge it advances a
// bus-cycle-level reference model and pushes the expected registered
// outputs into exp_q. A monitor on the falling edge pops and compares.
// The driver also makes a few direct checks for the named scenarios.
// ---------------------------------------------------------------------------
module tb_io_read_arbiter;

  localparam int N_SRC  = 4;
  localparam int SETTLE = 2;
  localparam int RW     = 26;

`ifdef IO_ARB_CONFLICT_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk28 = 1'b0;
  logic              rst;
  logic              ioreq;
  logic              rd;
  logic [N_SRC-1:0]  src_active;
  logic [8*N_SRC-1:0] src_data;
  logic [7:0]        d_out;
  logic              d_out_active;
  logic [N_SRC-1:0]  grant;
  logic              conflict;
  logic              conflict_clr;
  logic [7:0]        conflict_cnt;
  logic [N_SRC-1:0]  conflict_mask;
  logic [1:0]        dbg_state;

  always #18 clk28 = ~clk28;

  io_read_arbiter #(.N_SRC(N_SRC), .SETTLE(SETTLE)) dut (
    .clk28         (clk28),
    .rst           (rst),
    .ioreq         (ioreq),
    .rd            (rd),
    .src_active    (src_active),
    .src_data      (src_data),
    .d_out         (d_out),
    .d_out_active  (d_out_active),
    .grant         (grant),
    .conflict      (conflict),
    .conflict_clr  (conflict_clr),
    .conflict_cnt  (conflict_cnt),
    .conflict_mask (conflict_mask),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_k counts consecutive req-high samples since the bus cycle began. The
  // arbitration edge is the (SETTLE+1)-th such sample; any later sample is
  // the hold phase.
  int         m_k;
  bit         m_blocked;
  int         m_g;
  logic [3:0] m_grant;
  logic       m_act;
  logic [7:0] m_dout;
  logic       m_conf;
  logic [7:0] m_cnt;
  logic [3:0] m_mask;

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
    return d[8*i +: 8];
  endfunction

  task automatic model_reset();
    m_k = 0; m_blocked = 1'b1; m_g = -1;
    m_grant = '0; m_act = 1'b0; m_dout = 8'hFF; m_conf = 1'b0;
    m_cnt = '0; m_mask = '0;
  endtask

  task automatic model_step(input bit rq, input logic [3:0] a, input logic [31:0] d,
                            input bit r, input bit c);
    m_conf = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (c && LOG_EN) begin
        m_cnt = '0; m_mask = '0;
      end
      if (!rq) begin
        m_k = 0; m_blocked = 1'b0; m_g = -1;
        m_grant = '0; m_act = 1'b0; m_dout = 8'hFF;
      end else if (!m_blocked) begin
        if (m_k < SETTLE + 2) m_k++;
        if (m_k == SETTLE + 1) begin
          m_g = -1;
          for (int i = N_SRC - 1; i >= 0; i--) if (a[i]) m_g = i;
          m_grant = (m_g >= 0) ? 4'(1 << m_g) : 4'd0;
          m_act   = (a != 4'd0);
          m_dout  = (m_g >= 0) ? byte_of(d, m_g) : 8'hFF;
          if ($countones(a) >= 2) begin
            m_conf = 1'b1;
            if (LOG_EN && !c) begin
              if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
              m_mask = a;
            end
          end
        end else if (m_k == SETTLE + 2 && m_g >= 0 && a[m_g]) begin
          m_dout = byte_of(d, m_g);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // One call = one clk28 edge. req low is produced by dropping ioreq,
  // rd or both, chosen at random.
  task automatic drive(input bit rq, input logic [3:0] a, input logic [31:0] d,
                       input bit r, input bit c);
    rst = r; conflict_clr = c; src_active = a; src_data = d;
    if (rq) begin
      ioreq = 1'b1; rd = 1'b1;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin ioreq = 1'b0; rd = 1'b0; end
        1:       begin ioreq = 1'b1; rd = 1'b0; end
        default: begin ioreq = 1'b0; rd = 1'b1; end
      endcase
    end
    @(posedge clk28);
    model_step(rq, a, d, r, c);
    exp_q.push_back({m_grant, m_act, m_dout, m_conf, m_cnt, m_mask});
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [RW-1:0] e;
    forever begin
      @(negedge clk28);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_grant",         32'(grant),         32'(e[25:22]));
        check("mon_d_out_active",  32'(d_out_active),  32'(e[21]));
        check("mon_d_out",         32'(d_out),         32'(e[20:13]));
        check("mon_conflict",      32'(conflict),      32'(e[12]));
        check("mon_conflict_cnt",  32'(conflict_cnt),  32'(e[11:4]));
        check("mon_conflict_mask", 32'(conflict_mask), 32'(e[3:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [3:0]  a;
    int          len;

    rst = 1'b1; ioreq = 1'b0; rd = 1'b0; conflict_clr = 1'b0;
    src_active = '0; src_data = '1;
    model_reset();

    // Reset values.
    repeat (3) drive(1'b0, 4'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("rst_grant",    32'(grant),         32'd0);
    check("rst_d_act",    32'(d_out_active),  32'd0);
    check("rst_d_out",    32'(d_out),         32'hFF);
    check("rst_conflict", 32'(conflict),      32'd0);
    check("rst_cnt",      32'(conflict_cnt),  32'd0);
    check("rst_mask",     32'(conflict_mask), 32'd0);
    check("rst_state",    32'(dbg_state),     32'd0);
    repeat (2) drive(1'b0, 4'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Single source 2 with data 5A, req held for 6 edges.
    d = {8'h00, 8'h5A, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'b0100, d, 1'b0, 1'b0);
      if (i == 1) check("single_no_grant_early", 32'(grant), 32'd0);
      if (i == 2) begin
        check("single_grant", 32'(grant),        32'b0100);
        check("single_d_out", 32'(d_out),        32'h5A);
        check("single_d_act", 32'(d_out_active), 32'd1);
      end
    end
    check("single_d_act_before_release", 32'(d_out_active), 32'd1);
    drive(1'b0, 4'b0100, d, 1'b0, 1'b0);
    check("single_release_act",  32'(d_out_active), 32'd0);
    check("single_release_dout", 32'(d_out),        32'hFF);
    check("single_release_gnt",  32'(grant),        32'd0);

    // Overlap: sources 1 and 2.
    d = {8'h00, 8'h22, 8'h11, 8'h00};
    repeat (3) drive(1'b1, 4'b0110, d, 1'b0, 1'b0);
    check("overlap_grant",    32'(grant),         32'b0010);
    check("overlap_d_out",    32'(d_out),         32'h11);
    check("overlap_conflict", 32'(conflict),      32'd1);
    check("overlap_cnt",      32'(conflict_cnt),  LOG_EN ? 32'd1 : 32'd0);
    check("overlap_mask",     32'(conflict_mask), LOG_EN ? 32'b0110 : 32'd0);
    drive(1'b1, 4'b0110, d, 1'b0, 1'b0);
    check("overlap_pulse_one_cycle", 32'(conflict), 32'd0);
    drive(1'b0, 4'b0110, d, 1'b0, 1'b0);

    // No decoder.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd0, $urandom, 1'b0, 1'b0);
      if (i == 2) begin
        check("nodec_act",      32'(d_out_active), 32'd0);
        check("nodec_d_out",    32'(d_out),        32'hFF);
        check("nodec_grant",    32'(grant),        32'd0);
        check("nodec_conflict", 32'(conflict),     32'd0);
      end
    end
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);

    // Source 3 granted, source 0 asserts late, then source 3 drops.
    d = {8'h77, 8'h00, 8'h00, 8'h00};
    repeat (3) drive(1'b1, 4'b1000, d, 1'b0, 1'b0);
    check("late_grant3", 32'(grant), 32'b1000);
    check("late_dout",   32'(d_out), 32'h77);
    drive(1'b1, 4'b1001, {8'h77, 8'h00, 8'h00, 8'h01}, 1'b0, 1'b0);
    check("late_grant_stays", 32'(grant), 32'b1000);
    drive(1'b1, 4'b0001, {8'h99, 8'h00, 8'h00, 8'h01}, 1'b0, 1'b0);
    check("drop_dout_frozen", 32'(d_out),        32'h77);
    check("drop_act_high",    32'(d_out_active), 32'd1);
    drive(1'b1, 4'b0001, {8'h99, 8'h00, 8'h00, 8'h01}, 1'b0, 1'b0);
    check("drop_dout_frozen2", 32'(d_out), 32'h77);
    drive(1'b0, 4'b0001, 32'd0, 1'b0, 1'b0);
    check("drop_release_act", 32'(d_out_active), 32'd0);

    // Abort after one req-high edge.
    d = {8'h00, 8'h22, 8'h11, 8'h00};
    drive(1'b1, 4'b0110, d, 1'b0, 1'b0);
    drive(1'b0, 4'b0110, d, 1'b0, 1'b0);
    check("abort_grant",    32'(grant),    32'd0);
    check("abort_conflict", 32'(conflict), 32'd0);
    drive(1'b0, 4'b0110, d, 1'b0, 1'b0);
    check("abort_conflict_late", 32'(conflict), 32'd0);

    // Reset in HOLD with req still high.
    d = {8'h00, 8'h5A, 8'h00, 8'h00};
    repeat (3) drive(1'b1, 4'b0100, d, 1'b0, 1'b0);
    drive(1'b1, 4'b0100, d, 1'b1, 1'b0);
    check("rsthold_grant", 32'(grant),        32'd0);
    check("rsthold_act",   32'(d_out_active), 32'd0);
    check("rsthold_dout",  32'(d_out),        32'hFF);
    repeat (4) drive(1'b1, 4'b0100, d, 1'b0, 1'b0);
    check("rsthold_no_regrant", 32'(grant), 32'd0);
    drive(1'b0, 4'b0100, d, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 4'b0100, d, 1'b0, 1'b0);
    check("rsthold_regrant", 32'(grant), 32'b0100);
    drive(1'b0, 4'b0100, d, 1'b0, 1'b0);

    // 300 conflicting cycles saturate the counter.
    d = {8'h00, 8'h00, 8'hB2, 8'hA1};
    for (int i = 0; i < 300; i++) begin
      repeat (3) drive(1'b1, 4'b0011, d, 1'b0, 1'b0);
      drive(1'b0, 4'b0011, d, 1'b0, 1'b0);
    end
    check("sat_cnt",  32'(conflict_cnt),  LOG_EN ? 32'd255 : 32'd0);
    check("sat_mask", 32'(conflict_mask), LOG_EN ? 32'b0011 : 32'd0);

    // Clear on the same edge as a conflict.
    repeat (2) drive(1'b1, 4'b0011, d, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, d, 1'b0, 1'b1);
    check("clr_conflict", 32'(conflict),      32'd1);
    check("clr_cnt",      32'(conflict_cnt),  32'd0);
    check("clr_mask",     32'(conflict_mask), 32'd0);
    drive(1'b0, 4'b0011, d, 1'b0, 1'b0);

    // Random bus cycles with changing decode, sporadic reset and clear.
    a = 4'd0;
    for (int n = 0; n < 80; n++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) < 3) a = 4'($urandom_range(0, 15));
        drive(1'b1, a, $urandom, ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0));
      end
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) < 3) a = 4'($urandom_range(0, 15));
        drive(1'b0, a, $urandom, 1'b0, ($urandom_range(0, 19) == 0));
      end
    end

    repeat (2) drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk28);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
